// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the RV32I/RV64I decode stage:
//   - base opcode values of the nine recognised instruction classes
//   - bit index of each class inside the one-hot class vector (CLASS_W = 9)
//   - immediate-format enum (IMM_I/S/B/U/J/NONE)
//   - decFields_t, the XLEN-independent part of a decoded entry
//   - classify / immFormat / decodeFields helper functions
// No ports (package).
// ---------------------------------------------------------------------------
package decode_pkg;

   localparam int CLASS_W = 9;

   localparam logic [6:0] OPC_ALUREG = 7'b0110011;
   localparam logic [6:0] OPC_ALUIMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam int CLS_ALUREG = 0;
   localparam int CLS_ALUIMM = 1;
   localparam int CLS_BRANCH = 2;
   localparam int CLS_JALR   = 3;
   localparam int CLS_JAL    = 4;
   localparam int CLS_AUIPC  = 5;
   localparam int CLS_LUI    = 6;
   localparam int CLS_LOAD   = 7;
   localparam int CLS_STORE  = 8;

   // Classes that architecturally write rd: everything except Branch and Store.
   localparam logic [CLASS_W-1:0] WRITES_RD_MASK = 9'b0_1111_1011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } immFmt_e;

   typedef struct packed {
      logic [4:0]         rd;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [2:0]         funct3;
      logic               funct7b5;
      logic [CLASS_W-1:0] cls;
      logic               regWrite;
      logic               illegal;
      logic               muldiv;
   } decFields_t;

   // One-hot class of a raw instruction; all zero for an unrecognised encoding.
   function automatic logic [CLASS_W-1:0] classify(input logic [31:0] instr);
      logic [CLASS_W-1:0] cls;
      cls = '0;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:0])
            OPC_ALUREG: cls[CLS_ALUREG] = 1'b1;
            OPC_ALUIMM: cls[CLS_ALUIMM] = 1'b1;
            OPC_BRANCH: cls[CLS_BRANCH] = 1'b1;
            OPC_JALR:   cls[CLS_JALR]   = 1'b1;
            OPC_JAL:    cls[CLS_JAL]    = 1'b1;
            OPC_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
            OPC_LUI:    cls[CLS_LUI]    = 1'b1;
            OPC_LOAD:   cls[CLS_LOAD]   = 1'b1;
            OPC_STORE:  cls[CLS_STORE]  = 1'b1;
            default:    cls = '0;
         endcase
      end
      return cls;
   endfunction

   // Immediate layout selected by class; ALUreg and illegal entries carry no immediate.
   function automatic immFmt_e immFormat(input logic [CLASS_W-1:0] cls);
      immFmt_e fmt;
      if (cls[CLS_ALUIMM] || cls[CLS_JALR] || cls[CLS_LOAD]) begin
         fmt = IMM_I;
      end else if (cls[CLS_STORE]) begin
         fmt = IMM_S;
      end else if (cls[CLS_BRANCH]) begin
         fmt = IMM_B;
      end else if (cls[CLS_LUI] || cls[CLS_AUIPC]) begin
         fmt = IMM_U;
      end else if (cls[CLS_JAL]) begin
         fmt = IMM_J;
      end else begin
         fmt = IMM_NONE;
      end
      return fmt;
   endfunction

   // Field extraction; muldiv is left at 0 here and refined by the stage
   // when the M extension is built in.
   function automatic decFields_t decodeFields(input logic [31:0] instr);
      decFields_t f;
      f.rd       = instr[11:7];
      f.rs1      = instr[19:15];
      f.rs2      = instr[24:20];
      f.funct3   = instr[14:12];
      f.funct7b5 = instr[30];
      f.cls      = classify(instr);
      f.illegal  = (f.cls == '0);
      f.regWrite = (|(f.cls & WRITES_RD_MASK)) && (f.rd != 5'd0);
      f.muldiv   = 1'b0;
      return f;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Handshake bundle around the decode stage: the upstream (fetch) side and the
// downstream (register-read/execute) side.
//   upstream   : in_valid, in_ready, in_instr[31:0], in_pc[XLEN-1:0]
//   downstream : out_valid, out_ready, out_pc, out_rd, out_rs1, out_rs2,
//                out_funct3, out_funct7b5, out_imm, out_class[8:0],
//                out_reg_write, out_illegal, out_muldiv
// Modports: slave  = the decode stage itself
//           master = the environment around it (fetch + consumer)
// ---------------------------------------------------------------------------
interface decode_stage_if
   import decode_pkg::*;
#(
   parameter int XLEN = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_instr;
   logic [XLEN-1:0]    in_pc;

   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_pc;
   logic [4:0]         out_rd;
   logic [4:0]         out_rs1;
   logic [4:0]         out_rs2;
   logic [2:0]         out_funct3;
   logic               out_funct7b5;
   logic [XLEN-1:0]    out_imm;
   logic [CLASS_W-1:0] out_class;
   logic               out_reg_write;
   logic               out_illegal;
   logic               out_muldiv;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7b5, out_imm, out_class,
             out_reg_write, out_illegal, out_muldiv
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7b5, out_imm, out_class,
             out_reg_write, out_illegal, out_muldiv
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator.
//   instr [31:0]     in  : raw instruction
//   fmt   immFmt_e   in  : immediate layout (I/S/B/U/J/NONE)
//   imm   [XLEN-1:0] out : immediate, sign-extended from instr[31]
// ---------------------------------------------------------------------------
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [31:0]     instr,
   input  immFmt_e         fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (fmt)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Every 32-bit form already carries instr[31] in its MSB, so a signed
   // widening cast gives the RV64 sign extension directly.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I/RV64I decode stage with valid/ready on both sides.
// Instructions are decoded combinationally at the input and the results are
// captured on acceptance; the output side only presents stored entries.
//
// Parameters:
//   XLEN  : 32 or 64, width of PC and immediate
//   SKID  : 0 = single output register, in_ready = !out_valid | out_ready
//           1 = two-entry FIFO, in_ready registered ("not full")
//   CNT_W : width of the decoded-instruction counter
// Ports:
//   clk          in  : clock
//   rst_n        in  : synchronous active-low reset
//   flush        in  : drop all held entries and any same-edge input
//   bus          slave modport of decode_stage_if (both handshakes + fields)
//   decoded_cnt  out : entries consumed downstream, wraps modulo 2^CNT_W
// Build option:
//   DECODE_MEXT_EN : when defined, out_muldiv flags ALUreg with
//                    funct7 = 7'b0000001; otherwise out_muldiv is 0.
// ---------------------------------------------------------------------------
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int SKID  = 0,
   parameter int CNT_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   decode_stage_if.slave     bus,
   output logic [CNT_W-1:0]  decoded_cnt
);

   localparam int DEPTH = (SKID != 0) ? 2 : 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      decFields_t      fld;
   } entry_t;

   // ---------------------------------------------------------------- decode
   decFields_t      inFields;
   immFmt_e         inFmt;
   logic [XLEN-1:0] inImm;
   entry_t          newEntry;

   always_comb begin
      inFields = decodeFields(bus.in_instr);
`ifdef DECODE_MEXT_EN
      inFields.muldiv = inFields.cls[CLS_ALUREG] &&
                        (bus.in_instr[31:25] == 7'b0000001);
`endif
   end

   assign inFmt = immFormat(inFields.cls);

   imm_gen #(
      .XLEN (XLEN)
   ) uImmGen (
      .instr (bus.in_instr),
      .fmt   (inFmt),
      .imm   (inImm)
   );

   assign newEntry = '{pc: bus.in_pc, imm: inImm, fld: inFields};

   // ------------------------------------------------------------ entry store
   // Slot 0 is always the head; younger entries sit behind it and shift
   // forward on a pop, so the outputs come straight from slot 0.
   logic [1:0] countReg;
   logic [1:0] countNext;
   logic [1:0] writeIdx;
   logic       push;
   logic       pop;
   logic       inReady;
   logic       outValid;
   entry_t     slotReg  [DEPTH];
   entry_t     slotNext [DEPTH];

   assign outValid = (countReg != 2'd0);
   assign pop      = outValid & bus.out_ready;
   // flush wins over a simultaneous upstream handshake
   assign push     = bus.in_valid & inReady & ~flush;
   // new entry lands just behind whatever survives this edge
   assign writeIdx = countReg - {1'b0, pop};

   always_comb begin
      countNext = countReg + {1'b0, push} - {1'b0, pop};
      if (flush) begin
         countNext = 2'd0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : gSlot
         if (gi + 1 < DEPTH) begin : gShift
            always_comb begin
               slotNext[gi] = slotReg[gi];
               if (push && (writeIdx == 2'(gi))) begin
                  slotNext[gi] = newEntry;
               end else if (pop && (countReg > 2'(gi + 1))) begin
                  slotNext[gi] = slotReg[gi + 1];
               end
            end
         end else begin : gTail
            always_comb begin
               slotNext[gi] = slotReg[gi];
               if (push && (writeIdx == 2'(gi))) begin
                  slotNext[gi] = newEntry;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         countReg    <= 2'd0;
         decoded_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            slotReg[i] <= '0;
         end
      end else begin
         countReg <= countNext;
         // counts the pop even on a flush edge
         if (pop) begin
            decoded_cnt <= decoded_cnt + CNT_W'(1);
         end
         for (int i = 0; i < DEPTH; i++) begin
            slotReg[i] <= slotNext[i];
         end
      end
   end

   // -------------------------------------------------------------- in_ready
   generate
      if (SKID != 0) begin : gSkidReady
         logic inReadyReg;
         // Registered from the next occupancy, so it drops the cycle after
         // the FIFO fills and never depends on out_ready combinationally.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               inReadyReg <= 1'b1;
            end else begin
               inReadyReg <= (countNext != 2'd2);
            end
         end
         assign inReady = inReadyReg;
      end else begin : gPassReady
         assign inReady = ~outValid | bus.out_ready;
      end
   endgenerate

   // --------------------------------------------------------------- outputs
   assign bus.in_ready      = inReady;
   assign bus.out_valid     = outValid;
   assign bus.out_pc        = slotReg[0].pc;
   assign bus.out_imm       = slotReg[0].imm;
   assign bus.out_rd        = slotReg[0].fld.rd;
   assign bus.out_rs1       = slotReg[0].fld.rs1;
   assign bus.out_rs2       = slotReg[0].fld.rs2;
   assign bus.out_funct3    = slotReg[0].fld.funct3;
   assign bus.out_funct7b5  = slotReg[0].fld.funct7b5;
   assign bus.out_class     = slotReg[0].fld.cls;
   assign bus.out_reg_write = slotReg[0].fld.regWrite;
   assign bus.out_illegal   = slotReg[0].fld.illegal;
   assign bus.out_muldiv    = slotReg[0].fld.muldiv;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Two decode stages share one input stream: dutA (XLEN=32, SKID=0, CNT_W=32)
// and dutB (XLEN=64, SKID=1, CNT_W=4, so the counter wraps quickly). Each has
// its own out_ready. A queue-based model decodes instructions from the ISA
// field layouts and tracks occupancy, counters and ready for each instance.
// ---------------------------------------------------------------------------
module tb_decode_stage;

`ifdef DECODE_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstN;
   logic        flush;
   logic        inValid;
   logic        outReadyA;
   logic        outReadyB;
   logic [31:0] inInstr;
   logic [63:0] inPc;
   logic [31:0] cntA;
   logic [3:0]  cntB;

   decode_stage_if #(.XLEN(32)) busA ();
   decode_stage_if #(.XLEN(64)) busB ();

   assign busA.in_valid  = inValid;
   assign busA.in_instr  = inInstr;
   assign busA.in_pc     = inPc[31:0];
   assign busA.out_ready = outReadyA;
   assign busB.in_valid  = inValid;
   assign busB.in_instr  = inInstr;
   assign busB.in_pc     = inPc;
   assign busB.out_ready = outReadyB;

   decode_stage #(.XLEN(32), .SKID(0), .CNT_W(32)) dutA (
      .clk         (clk),
      .rst_n       (rstN),
      .flush       (flush),
      .bus         (busA.slave),
      .decoded_cnt (cntA)
   );

   decode_stage #(.XLEN(64), .SKID(1), .CNT_W(4)) dutB (
      .clk         (clk),
      .rst_n       (rstN),
      .flush       (flush),
      .bus         (busB.slave),
      .decoded_cnt (cntB)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [8:0]  cls;
      logic        rw;
      logic        ill;
      logic        md;
   } ent_t;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic [31:0] cnt;
      ent_t        e;
   } view_t;

   ent_t        qA[$];
   ent_t        qB[$];
   int unsigned mCntA;
   int unsigned mCntB;
   int          compares = 0;
   int          errors   = 0;

   // ------------------------------------------------------ reference decode
   function automatic ent_t refDecode(logic [31:0] instr, logic [63:0] pc);
      ent_t   r;
      longint s;
      longint u;
      int     kind;
      r    = '0;
      s    = $signed(instr);
      u    = {32'b0, instr};
      kind = -1;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:0])
            7'h33: kind = 0;
            7'h13: kind = 1;
            7'h63: kind = 2;
            7'h67: kind = 3;
            7'h6F: kind = 4;
            7'h17: kind = 5;
            7'h37: kind = 6;
            7'h03: kind = 7;
            7'h23: kind = 8;
            default: kind = -1;
         endcase
      end
      r.pc   = pc;
      r.rd   = instr[11:7];
      r.rs1  = instr[19:15];
      r.rs2  = instr[24:20];
      r.f3   = instr[14:12];
      r.f7b5 = instr[30];
      r.ill  = (kind < 0);
      if (kind >= 0) r.cls = 9'(1) << kind;
      case (kind)
         1, 3, 7: r.imm = s >>> 20;
         8:       r.imm = ((s >>> 25) * 32) + ((u >> 7) & 31);
         2:       r.imm = ((s >>> 31) * 4096) + (((u >> 7) & 1) * 2048)
                          + (((u >> 25) & 63) * 32) + (((u >> 8) & 15) * 2);
         5, 6:    r.imm = (s >>> 12) * 4096;
         4:       r.imm = ((s >>> 31) * 1048576) + (((u >> 12) & 255) * 4096)
                          + (((u >> 20) & 1) * 2048) + (((u >> 21) & 1023) * 2);
         default: r.imm = 64'd0;
      endcase
      r.rw = (kind inside {0, 1, 3, 4, 5, 6, 7}) && (r.rd != 5'd0);
      r.md = MEXT && (kind == 0) && (instr[31:25] == 7'h01);
      return r;
   endfunction

   // --------------------------------------------------- expected / observed
   // Data fields only matter while valid; the immediate of an illegal entry
   // is not defined, so it is zeroed on both sides.
   function automatic view_t expA();
      view_t v;
      v       = '0;
      v.valid = (qA.size() > 0);
      v.ready = (qA.size() == 0) || outReadyA;
      v.cnt   = mCntA;
      if (v.valid) begin
         v.e     = qA[0];
         v.e.pc  = {32'b0, qA[0].pc[31:0]};
         v.e.imm = qA[0].ill ? 64'd0 : {32'b0, qA[0].imm[31:0]};
      end
      return v;
   endfunction

   function automatic view_t expB();
      view_t v;
      v       = '0;
      v.valid = (qB.size() > 0);
      v.ready = (qB.size() < 2);
      v.cnt   = mCntB;
      if (v.valid) begin
         v.e = qB[0];
         if (qB[0].ill) v.e.imm = 64'd0;
      end
      return v;
   endfunction

   function automatic view_t gotA();
      view_t v;
      v       = '0;
      v.valid = busA.out_valid;
      v.ready = busA.in_ready;
      v.cnt   = cntA;
      if (busA.out_valid !== 1'b0) begin
         v.e.pc   = {32'b0, busA.out_pc};
         v.e.imm  = (busA.out_illegal === 1'b1) ? 64'd0 : {32'b0, busA.out_imm};
         v.e.rd   = busA.out_rd;
         v.e.rs1  = busA.out_rs1;
         v.e.rs2  = busA.out_rs2;
         v.e.f3   = busA.out_funct3;
         v.e.f7b5 = busA.out_funct7b5;
         v.e.cls  = busA.out_class;
         v.e.rw   = busA.out_reg_write;
         v.e.ill  = busA.out_illegal;
         v.e.md   = busA.out_muldiv;
      end
      return v;
   endfunction

   function automatic view_t gotB();
      view_t v;
      v       = '0;
      v.valid = busB.out_valid;
      v.ready = busB.in_ready;
      v.cnt   = {28'b0, cntB};
      if (busB.out_valid !== 1'b0) begin
         v.e.pc   = busB.out_pc;
         v.e.imm  = (busB.out_illegal === 1'b1) ? 64'd0 : busB.out_imm;
         v.e.rd   = busB.out_rd;
         v.e.rs1  = busB.out_rs1;
         v.e.rs2  = busB.out_rs2;
         v.e.f3   = busB.out_funct3;
         v.e.f7b5 = busB.out_funct7b5;
         v.e.cls  = busB.out_class;
         v.e.rw   = busB.out_reg_write;
         v.e.ill  = busB.out_illegal;
         v.e.md   = busB.out_muldiv;
      end
      return v;
   endfunction

   // ------------------------------------------------------------- stimulus
   // Applies the edge to the model using the inputs currently driven, then
   // lets the DUTs take the same edge and returns at the following negedge.
   task automatic advance();
      bit popA, pushA, popB, pushB;
      if (!rstN) begin
         qA.delete();
         qB.delete();
         mCntA = 0;
         mCntB = 0;
      end else begin
         popA  = (qA.size() > 0) && outReadyA;
         pushA = inValid && !flush && ((qA.size() == 0) || outReadyA);
         popB  = (qB.size() > 0) && outReadyB;
         pushB = inValid && !flush && (qB.size() < 2);
         if (popA) begin
            void'(qA.pop_front());
            mCntA = mCntA + 1;
         end
         if (popB) begin
            void'(qB.pop_front());
            mCntB = (mCntB + 1) % 16;
         end
         if (flush) begin
            qA.delete();
            qB.delete();
         end else begin
            if (pushA) qA.push_back(refDecode(inInstr, inPc));
            if (pushB) qB.push_back(refDecode(inInstr, inPc));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] randInstr();
      logic [6:0]  opcTab [9];
      logic [31:0] x;
      int          pick;
      opcTab = '{7'h33, 7'h13, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h03, 7'h23};
      x    = $urandom;
      pick = $urandom_range(0, 11);
      if (pick < 9) begin
         x[6:0] = opcTab[pick];
      end else if (pick == 9) begin
         x[6:0]   = 7'h33;
         x[31:25] = 7'h01;
      end else if (pick == 10) begin
         x[6:0] = opcTab[$urandom_range(0, 8)];
         x[1:0] = 2'($urandom_range(0, 2));
      end
      return x;
   endfunction

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      logic [63:0] zA;
      logic [63:0] zB;
      rstN      = 1'b0;
      flush     = 1'b0;
      inValid   = 1'b1;
      inInstr   = randInstr();
      inPc      = {$urandom, $urandom};
      outReadyA = 1'b1;
      outReadyB = 1'b0;
      advance();
      advance();
      compares++;
      if (gotA() !== expA()) begin
         errors++;
         $display("FAIL reset_viewA got=%h want=%h", gotA(), expA());
      end
      compares++;
      if (gotB() !== expB()) begin
         errors++;
         $display("FAIL reset_viewB got=%h want=%h", gotB(), expB());
      end
      zA = {busA.out_pc, busA.out_imm} | 64'(busA.out_class)
           | 64'({busA.out_illegal, busA.out_muldiv, busA.out_reg_write, busA.out_rd});
      zB = busB.out_pc | busB.out_imm | 64'(busB.out_class)
           | 64'({busB.out_illegal, busB.out_muldiv, busB.out_reg_write, busB.out_rd});
      compares++;
      if ({zA, zB, busA.in_ready, busB.in_ready} !== {128'd0, 2'b11}) begin
         errors++;
         $display("FAIL reset_zero_outputs got=%h want=%h",
                  {zA, zB, busA.in_ready, busB.in_ready}, {128'd0, 2'b11});
      end
      rstN = 1'b1;
      inValid = 1'b0;
      advance();
   endtask

   task automatic test_directed();
      logic [31:0] tInstr [6];
      logic [8:0]  tCls   [6];
      logic [63:0] tImm   [6];
      logic [2:0]  tFlags [6];   // {reg_write, illegal, muldiv}
      tInstr = '{32'h00500093, 32'hFFC0A103, 32'h0020A423,
                 32'h008000EF, 32'h00000000, 32'h022081B3};
      tCls   = '{9'h002, 9'h080, 9'h100, 9'h010, 9'h000, 9'h001};
      tImm   = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 64'd8, 64'd0, 64'd0};
      tFlags = '{3'b100, 3'b100, 3'b000, 3'b100, 3'b010, {2'b10, MEXT}};
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      for (int i = 0; i < 6; i++) begin
         inValid = 1'b1;
         inInstr = tInstr[i];
         inPc    = 64'h8000_0000 + 64'(4 * i);
         advance();
         inValid = 1'b0;
         compares++;
         if (gotA() !== expA()) begin
            errors++;
            $display("FAIL directed_viewA[%0d] got=%h want=%h", i, gotA(), expA());
         end
         compares++;
         if (gotB() !== expB()) begin
            errors++;
            $display("FAIL directed_viewB[%0d] got=%h want=%h", i, gotB(), expB());
         end
         compares++;
         if ({busB.out_valid, busB.out_class, busB.out_reg_write, busB.out_illegal,
              busB.out_muldiv} !== {1'b1, tCls[i], tFlags[i]}) begin
            errors++;
            $display("FAIL directed_fields[%0d] got=%h want=%h", i,
                     {busB.out_valid, busB.out_class, busB.out_reg_write,
                      busB.out_illegal, busB.out_muldiv}, {1'b1, tCls[i], tFlags[i]});
         end
         if (tFlags[i][1] == 1'b0) begin
            compares++;
            if ({busB.out_imm, busA.out_imm} !== {tImm[i], tImm[i][31:0]}) begin
               errors++;
               $display("FAIL directed_imm[%0d] got=%h want=%h", i,
                        {busB.out_imm, busA.out_imm}, {tImm[i], tImm[i][31:0]});
            end
         end
         if (i == 0) begin
            compares++;
            if ({cntA, cntB} !== {32'd0, 4'd0}) begin
               errors++;
               $display("FAIL directed_cnt_before got=%h want=0", {cntA, cntB});
            end
            advance();
            compares++;
            if ({cntA, cntB} !== {32'd1, 4'd1}) begin
               errors++;
               $display("FAIL directed_cnt_after got=%h want=%h", {cntA, cntB},
                        {32'd1, 4'd1});
            end
         end else begin
            advance();
         end
      end
   endtask

   task automatic test_back_to_back();
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      inValid   = 1'b1;
      for (int i = 0; i < 12; i++) begin
         inInstr = randInstr();
         inPc    = {$urandom, $urandom};
         advance();
         compares++;
         if (gotA() !== expA()) begin
            errors++;
            $display("FAIL b2b_viewA[%0d] got=%h want=%h", i, gotA(), expA());
         end
         compares++;
         if (gotB() !== expB()) begin
            errors++;
            $display("FAIL b2b_viewB[%0d] got=%h want=%h", i, gotB(), expB());
         end
      end
      inValid = 1'b0;
      advance();
   endtask

   task automatic test_skid_stall();
      outReadyA = 1'b0;
      outReadyB = 1'b0;
      inValid   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         inInstr = randInstr();
         inPc    = {$urandom, $urandom};
         advance();
         compares++;
         if (gotB() !== expB()) begin
            errors++;
            $display("FAIL stall_viewB[%0d] got=%h want=%h", k, gotB(), expB());
         end
         compares++;
         if (gotA() !== expA()) begin
            errors++;
            $display("FAIL stall_viewA[%0d] got=%h want=%h", k, gotA(), expA());
         end
         compares++;
         if (busB.in_ready !== (k == 0)) begin
            errors++;
            $display("FAIL stall_in_ready[%0d] got=%b want=%b", k, busB.in_ready, k == 0);
         end
      end
      inValid   = 1'b0;
      outReadyA = 1'b1;
      outReadyB = 1'b1;
      for (int k = 0; k < 3; k++) begin
         advance();
         compares++;
         if (gotB() !== expB()) begin
            errors++;
            $display("FAIL drain_viewB[%0d] got=%h want=%h", k, gotB(), expB());
         end
         compares++;
         if (gotA() !== expA()) begin
            errors++;
            $display("FAIL drain_viewA[%0d] got=%h want=%h", k, gotA(), expA());
         end
      end
   endtask

   task automatic test_flush();
      outReadyA = 1'b0;
      outReadyB = 1'b0;
      inValid   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         inInstr = randInstr();
         advance();
      end
      flush     = 1'b1;
      outReadyA = 1'b1;     // dutA pops on the flush edge, dutB does not
      inInstr   = randInstr();
      advance();
      flush   = 1'b0;
      inValid = 1'b0;
      compares++;
      if ({busA.out_valid, busB.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL flush_valid got=%b want=00", {busA.out_valid, busB.out_valid});
      end
      compares++;
      if (gotA() !== expA()) begin
         errors++;
         $display("FAIL flush_viewA got=%h want=%h", gotA(), expA());
      end
      compares++;
      if (gotB() !== expB()) begin
         errors++;
         $display("FAIL flush_viewB got=%h want=%h", gotB(), expB());
      end
      advance();
      compares++;
      if ({busA.out_valid, busB.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL flush_hold got=%b want=00", {busA.out_valid, busB.out_valid});
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         inValid   = ($urandom_range(0, 3) != 0);
         outReadyA = ($urandom_range(0, 2) != 0);
         outReadyB = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         inInstr   = randInstr();
         inPc      = {$urandom, $urandom};
         advance();
         compares++;
         if (gotA() !== expA()) begin
            errors++;
            $display("FAIL random_viewA[%0d] got=%h want=%h", i, gotA(), expA());
         end
         compares++;
         if (gotB() !== expB()) begin
            errors++;
            $display("FAIL random_viewB[%0d] got=%h want=%h", i, gotB(), expB());
         end
      end
      flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      outReadyA = 1'b0;
      outReadyB = 1'b0;
      inValid   = 1'b1;
      inInstr   = randInstr();
      advance();
      rstN    = 1'b0;
      inInstr = randInstr();
      advance();
      compares++;
      if (gotA() !== expA()) begin
         errors++;
         $display("FAIL reset_mid_viewA got=%h want=%h", gotA(), expA());
      end
      compares++;
      if (gotB() !== expB()) begin
         errors++;
         $display("FAIL reset_mid_viewB got=%h want=%h", gotB(), expB());
      end
      rstN    = 1'b1;
      inValid = 1'b0;
      advance();
   endtask

   initial begin
      rstN      = 1'b0;
      flush     = 1'b0;
      inValid   = 1'b0;
      outReadyA = 1'b0;
      outReadyB = 1'b0;
      inInstr   = '0;
      inPc      = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_back_to_back();
      test_skid_stall();
      test_flush();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage with valid/ready handshakes on both sides. It sits between fetch and register-read/execute. It classifies the opcode and extracts register indices, funct fields and the sign-extended immediate. It also flags illegal encodings, counts decoded instructions, and optionally holds a second entry in a skid buffer so `in_ready` is fully registered.

## Interface
- `XLEN`, 32 — datapath width (32 or 64); PC and immediate width
- `SKID`, 0 — 0: single output register; 1: two-entry skid buffer
- `CNT_W`, 32 — width of decoded-instruction counter
- `clk` in 1 — clock
- `rst_n` in 1 — synchronous, active-low reset; single clock domain
- `flush` in 1 — discard all held entries
- `in_valid` in 1 / `in_ready` out 1 — upstream handshake
- `in_instr` in 32 — raw instruction
- `in_pc` in XLEN — instruction PC
- `out_valid` out 1 / `out_ready` in 1 — downstream handshake
- `out_pc` out XLEN — PC of the presented entry
- `out_rd`, `out_rs1`, `out_rs2` out 5 each — register indices
- `out_funct3` out 3, `out_funct7b5` out 1 — ALU sub-op fields
- `out_imm` out XLEN — immediate, sign-extended to XLEN
- `out_class` out 9 — one-hot class; bit order [0]ALUreg [1]ALUimm [2]Branch [3]JALR [4]JAL [5]AUIPC [6]LUI [7]Load [8]Store; all zero when illegal
- `out_reg_write` out 1 — entry writes rd
- `out_illegal` out 1 — unrecognised encoding
- `out_muldiv` out 1 — M-extension op (see Configuration)
- `decoded_cnt` out CNT_W — count of entries consumed downstream

## Operation
- Transfer occurs when valid and ready are both high on a rising edge, per side.
- Decode is combinational on `in_instr`; results are captured at acceptance, with no decode on the output side.
- Immediate format by class: I (ALUimm, JALR, Load), S (Store), B (Branch), U (LUI, AUIPC), J (JAL), zero for ALUreg. Sign bit is instr[31], extended to XLEN.
- Illegal: instr[1:0] != 2'b11 or opcode not in the nine classes. In that case `out_illegal`=1, `out_class`=0, `out_reg_write`=0, and the entry still flows downstream.
- `out_reg_write` = (ALUreg | ALUimm | Load | LUI | AUIPC | JAL | JALR) & (rd != 0).
- SKID=0: `in_ready` = !out_valid | out_ready (combinational pass-through of `out_ready`).
- SKID=1: 2-entry FIFO. `in_ready` = registered "not full". The head drives the outputs. Simultaneous push and pop when holding 1 entry keeps the count at 1. Push is never accepted when full.
- `flush`: all entries are invalidated on that edge, and any simultaneous input handshake is dropped (flush wins). `decoded_cnt` is unaffected by the flush itself but still counts a pop on the same edge.
- `decoded_cnt` increments on every output handshake and wraps modulo 2^CNT_W.

## Timing
- Latency: an entry accepted at edge N is presented with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: 1 instruction/cycle with `out_ready` held high, for both SKID values.
- SKID=1: after `out_ready` drops, one further input may be accepted. `in_ready` falls the cycle after the FIFO becomes full.
- Reset (any cycle, including mid-transfer): `out_valid`=0 and FIFO empty. All data outputs are 0, including `out_class`=0, `out_illegal`=0 and `out_muldiv`=0. `decoded_cnt`=0. `in_ready`=1 after reset in both SKID modes.
- Held outputs are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `DECODE_MEXT_EN` defined: `out_muldiv`=1 for ALUreg with funct7=7'b0000001. Class stays ALUreg and `out_reg_write` follows the normal rule.
- Not defined: `out_muldiv` is tied to 0, and funct7=0000001 ALUreg decodes as plain ALUreg with no illegal flag.

## Structure
- `decode_pkg`: opcode localparams, class bit-index constants, immediate-format enum (`IMM_I/S/B/U/J/NONE`), `CLASS_W`=9.
- One sub-module `imm_gen` (instr + format → XLEN-bit immediate), combinational.
- FIFO/output register and counter live in `decode_stage`.

## Test plan
- `0x00500093` (addi x1,x0,5), `out_ready`=1 → next cycle: class bit1, rd=1, imm=5, reg_write=1, illegal=0; `decoded_cnt` 0→1.
- `0xFFC0A103` (lw x2,-4(x1)) → class bit7, rs1=1, rd=2, imm=0xFFFFFFFC (XLEN=32) / 0xFFFF_FFFF_FFFF_FFFC (XLEN=64).
- `0x0020A423` (sw x2,8(x1)) → class bit8, imm=8, reg_write=0. `0x008000EF` (jal x1,+8) → class bit4, imm=8, reg_write=1.
- `0x00000000` → illegal=1, class=0, reg_write=0; entry still handed off downstream.
- SKID=1, `out_ready`=0, back-to-back valid inputs → two accepted, `in_ready`=0 on the third cycle, outputs stable. Release `out_ready` → entries drain in order. Assert `flush` with `in_valid`=1 → `out_valid`=0 next cycle, no entry captured.
- `0x022081B3` (mul x3,x1,x2) → with `DECODE_MEXT_EN`: muldiv=1, class bit0, reg_write=1; without: muldiv=0.
